kb_event_fifo: RTL and testbench

Buffers keyboard events between the MEGA65 smart-keyboard decoder and the CPU-visible SCANCODE/KBSTATUS registers. Each event is one scancode with its extended/released flags. A burst of key events therefore queues instead of overwriting the single scancode latch. The block sits directly downstream of the decoder's `new_key`/`scancode`/`extended`/`released` outputs and feeds the scancode and status read-back path of `ps2_keyb`.

---
 rtl/kb_event_fifo_if.sv | 39 +++
 rtl/kb_event_fifo.sv | 125 ++++++++++++
 tb/tb_kb_event_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/kb_event_fifo_if.sv
// kb_event_fifo_if
//   Bundles the keyboard-event FIFO signals into one interface.
//   master : the decoder / CPU register side (drives events, read strobes,
//            flush; observes head entry and status).
//   slave  : the FIFO itself.
//   Signals:
//     new_key, scancode, extended, released : event strobe and payload
//     rd_active, st_read, clear              : SCANCODE read, KBSTATUS read, flush
//     head_code, head_ext, head_rls          : oldest entry (zero when empty)
//     pending, overflow, count               : status
interface kb_event_fifo_if #(
    parameter int AW = 4
);
    logic          new_key;
    logic [7:0]    scancode;
    logic          extended;
    logic          released;
    logic          rd_active;
    logic          st_read;
    logic          clear;
    logic [7:0]    head_code;
    logic          head_ext;
    logic          head_rls;
    logic          pending;
    logic          overflow;
    logic [AW:0]   count;

    modport master (
        output new_key, scancode, extended, released,
        output rd_active, st_read, clear,
        input  head_code, head_ext, head_rls, pending, overflow, count
    );

    modport slave (
        input  new_key, scancode, extended, released,
        input  rd_active, st_read, clear,
        output head_code, head_ext, head_rls, pending, overflow, count
    );
endinterface

// File: rtl/kb_event_fifo.sv
// kb_event_fifo
//   Queues keyboard events (scancode + extended/released flags) between the
//   smart-keyboard decoder and the CPU-visible SCANCODE/KBSTATUS registers.
//   A push happens on the rising edge of new_key; a pop happens when a CPU
//   read of SCANCODE ends (falling edge of rd_active), so the head value is
//   stable for the whole read. Head and status outputs are registered.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : kb_event_fifo_if.slave (events in, read strobes, head/status out)
module kb_event_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    kb_event_fifo_if.slave   bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Entry layout: {ext, rls, code}
    logic [9:0]    mem [DEPTH];

    logic          nk_q, rd_q, st_q;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   count_q, count_d;
    logic          pending_q, pending_d;
    logic [9:0]    head_q, head_d;

    logic          push_evt, pop_evt, st_fall;
    logic          pop_ok, push_ok, drop;
    logic          mem_we;
    logic [9:0]    mem_wdata;

    always_comb begin
        push_evt  = bus.new_key & ~nk_q;
        pop_evt   = ~bus.rd_active & rd_q;
        st_fall   = ~bus.st_read & st_q;
        // A pop on an empty FIFO never displayed anything, so it is ignored.
        pop_ok    = pop_evt && (cnt_q != '0);
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        drop      = push_evt && (cnt_q == FULL_CNT) && !pop_ok;
        push_ok   = push_evt && !drop;

        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_wdata = {bus.extended, bus.released, bus.scancode};

        if (bus.clear) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push_ok) begin
                mem_we = 1'b1;
                wp_d   = wp_q + 1'b1;
            end
            if (pop_ok) begin
                rp_d = rp_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt_d = cnt_q - 1'b1;
            end
            // A fresh drop wins over a status-read clear on the same edge.
            if (drop) begin
                ovf_d = 1'b1;
            end else if (st_fall) begin
                ovf_d = 1'b0;
            end
        end

        // Output stage samples the state after the edge that changed it.
        count_d   = cnt_q;
        pending_d = (cnt_q != '0);
        head_d    = (cnt_q == '0) ? 10'd0 : mem[rp_q];
    end

    // Storage array: no reset, so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk_q      <= 1'b0;
            rd_q      <= 1'b0;
            st_q      <= 1'b0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            pending_q <= 1'b0;
            head_q    <= '0;
        end else begin
            nk_q      <= bus.new_key;
            rd_q      <= bus.rd_active;
            st_q      <= bus.st_read;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            head_q    <= head_d;
        end
    end

    assign bus.head_ext  = head_q[9];
    assign bus.head_rls  = head_q[8];
    assign bus.head_code = head_q[7:0];
    assign bus.pending   = pending_q;
    assign bus.overflow  = ovf_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_kb_event_fifo.sv
module tb_kb_event_fifo;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    kb_event_fifo_if #(.AW(4)) bus ();

    kb_event_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit       is_pop;
        bit [7:0] code;
        bit       ext;
        bit       rls;
        bit [7:0] e_code;
        bit       e_ext;
        bit       e_rls;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit p, bit [7:0] c, bit x, bit r,
                                bit [7:0] ec, bit ex, bit er, int en);
        vec_t v;
        v.is_pop = p; v.code = c; v.ext = x; v.rls = r;
        v.e_code = ec; v.e_ext = ex; v.e_rls = er; v.e_cnt = en;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit [7:0] c, input bit x, input bit r);
        bus.new_key = 1'b1; bus.scancode = c; bus.extended = x; bus.released = r;
        tick();
        bus.new_key = 1'b0;
        tick();
        $display("push code=0x%02h ext=%0b rls=%0b -> count=%0d", c, x, r, bus.count);
    endtask

    task automatic pop(input int hold);
        bus.rd_active = 1'b1;
        repeat (hold) tick();
        bus.rd_active = 1'b0;
        tick();
        tick();
    endtask

    // Checks the head during a read, then pops it.
    task automatic read_chk(input string name, input bit [7:0] c, input bit x, input bit r);
        bus.rd_active = 1'b1;
        tick();
        chk({name, "_code"}, bus.head_code, c);
        chk({name, "_ext"}, bus.head_ext, x);
        chk({name, "_rls"}, bus.head_rls, r);
        tick();
        bus.rd_active = 1'b0;
        tick();
        tick();
        $display("read %s code=0x%02h -> count=%0d", name, c, bus.count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.new_key = 0; bus.scancode = 0; bus.extended = 0; bus.released = 0;
        bus.rd_active = 0; bus.st_read = 0; bus.clear = 0;
        #3;
        chk("rst_count", bus.count, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_head", bus.head_code, 0);
        chk("rst_ovf", bus.overflow, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single event and ordering table.
        vecs.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 8'h1C, 0, 0, 8'h1C, 0, 0, 1));
        vecs.push_back(mk(0, 8'h75, 1, 1, 8'h1C, 0, 0, 2));
        vecs.push_back(mk(0, 8'h5A, 0, 0, 8'h1C, 0, 0, 3));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'h75, 1, 1, 2));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'h5A, 0, 0, 1));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h00, 0, 0, 8'h00, 0, 0, 0)); // pop on empty
        foreach (vecs[i]) begin
            if (vecs[i].is_pop) pop(5);
            else push(vecs[i].code, vecs[i].ext, vecs[i].rls);
            chk($sformatf("vec%0d_code", i), bus.head_code, vecs[i].e_code);
            chk($sformatf("vec%0d_ext", i), bus.head_ext, vecs[i].e_ext);
            chk($sformatf("vec%0d_rls", i), bus.head_rls, vecs[i].e_rls);
            chk($sformatf("vec%0d_cnt", i), bus.count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_pend", i), bus.pending, vecs[i].e_cnt != 0);
            chk($sformatf("vec%0d_ovf", i), bus.overflow, 0);
        end

        // Overflow: 17 pushes, last one dropped.
        for (int i = 1; i <= 17; i++) push(8'(i), 0, 0);
        chk("ovf_count", bus.count, 16);
        chk("ovf_flag", bus.overflow, 1);
        bus.st_read = 1'b1; tick(); tick();
        chk("ovf_hold_during_st", bus.overflow, 1);
        bus.st_read = 1'b0; tick(); tick();
        chk("ovf_cleared", bus.overflow, 0);
        for (int i = 1; i <= 16; i++) read_chk($sformatf("ovf_rd%0d", i), 8'(i), 0, 0);
        chk("ovf_empty_cnt", bus.count, 0);
        chk("ovf_empty_head", bus.head_code, 0);

        // Simultaneous push and pop while full.
        for (int i = 0; i < 16; i++) push(8'(8'h21 + i), 0, 0);
        bus.rd_active = 1'b1;
        repeat (3) tick();
        bus.rd_active = 1'b0;
        bus.new_key = 1'b1; bus.scancode = 8'h99;
        tick();
        bus.new_key = 1'b0;
        tick();
        $display("push+pop full code=0x99 -> count=%0d", bus.count);
        chk("sim_count", bus.count, 16);
        chk("sim_ovf", bus.overflow, 0);
        for (int i = 1; i < 16; i++) read_chk($sformatf("sim_rd%0d", i), 8'(8'h21 + i), 0, 0);
        read_chk("sim_rd16", 8'h99, 0, 0);
        chk("sim_empty", bus.count, 0);

        // Wrap-around: 40 push/pop pairs.
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h40 + i), i[0], i[1]);
            read_chk($sformatf("wrap%0d", i), 8'(8'h40 + i), i[0], i[1]);
        end
        chk("wrap_count", bus.count, 0);

        // Clear after 5 pushes.
        for (int i = 0; i < 5; i++) push(8'(8'hA0 + i), 0, 0);
        chk("pre_clear_cnt", bus.count, 5);
        bus.clear = 1'b1; tick();
        bus.clear = 1'b0; tick();
        $display("clear -> count=%0d", bus.count);
        chk("clr_count", bus.count, 0);
        chk("clr_pending", bus.pending, 0);
        chk("clr_head", bus.head_code, 0);

        // Reset asserted mid-burst.
        for (int i = 0; i < 3; i++) push(8'(8'hC0 + i), 1, 0);
        chk("prerst_cnt", bus.count, 3);
        bus.new_key = 1'b1; bus.scancode = 8'hCF;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-burst -> count=%0d", bus.count);
        chk("arst_count", bus.count, 0);
        chk("arst_pending", bus.pending, 0);
        chk("arst_head", bus.head_code, 0);
        chk("arst_ext", bus.head_ext, 0);
        bus.new_key = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
